// File: rtl/spi_reg_sequencer.sv
// Frame-level register sequencer behind an SPI byte receiver: header byte selects
// read/write and start address, following bytes stream data with auto-increment.
module spi_reg_sequencer #(
  parameter int          NREGS     = 16,
  parameter int          AW        = 4,
  parameter logic [7:0]  RESET_VAL = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               SSEL,
  input  logic [7:0]         cmd,
  input  logic               cmd_valid,
  output logic [NREGS*8-1:0] regs,
  output logic               wr_strobe,
  output logic [AW-1:0]      wr_addr,
  output logic [7:0]         tx_byte,
  output logic               tx_load,
  output logic               addr_err
);

  typedef enum logic [2:0] {IDLE, HDR, WDATA, RDATA, DROP} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d, ptr_inc, tx_addr;
  logic          addr_err_q, addr_err_d;
  logic          wr_en, tx_en;
  logic [7:0]    regs_q [NREGS];
  logic          wr_strobe_q, tx_load_q;
  logic [AW-1:0] wr_addr_q;
  logic [7:0]    tx_byte_q;

  // The synchroniser is left out of reset so a reset while SSEL is held low
  // cannot fabricate a falling edge; the frame must restart with a real edge.
  logic ssel_meta_q, ssel_sync_q, ssel_prev_q;
  logic ssel_fall, ssel_rise;

  always_ff @(posedge clk) begin
    ssel_meta_q <= SSEL;
    ssel_sync_q <= ssel_meta_q;
    ssel_prev_q <= ssel_sync_q;
  end

  assign ssel_fall = ssel_prev_q & ~ssel_sync_q;
  assign ssel_rise = ~ssel_prev_q & ssel_sync_q;

  assign ptr_inc = (ptr_q == AW'(NREGS - 1)) ? '0 : ptr_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    addr_err_d = addr_err_q;
    wr_en      = 1'b0;
    tx_en      = 1'b0;
    tx_addr    = ptr_q;
    case (state_q)
      HDR: if (cmd_valid) begin
        ptr_d = cmd[AW-1:0];
        if (int'(cmd[6:0]) >= NREGS) begin
          addr_err_d = 1'b1;
          state_d    = DROP;
        end else begin
          addr_err_d = 1'b0;
          if (cmd[7]) begin
            state_d = WDATA;
          end else begin
            state_d = RDATA;
            tx_en   = 1'b1;
            tx_addr = cmd[AW-1:0];
          end
        end
      end
      WDATA: if (cmd_valid) begin
        wr_en = 1'b1;
        ptr_d = ptr_inc;
      end
      RDATA: if (cmd_valid) begin
        ptr_d   = ptr_inc;
        tx_en   = 1'b1;
        tx_addr = ptr_inc;
      end
      default: ;
    endcase
    // A byte coinciding with frame end is still consumed above.
    if (state_q != IDLE && ssel_rise) state_d = IDLE;
    if (ssel_fall) state_d = HDR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      addr_err_q  <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      tx_byte_q   <= 8'h00;
      tx_load_q   <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      addr_err_q  <= addr_err_d;
      wr_strobe_q <= wr_en;
      tx_load_q   <= tx_en;
      if (wr_en) begin
        regs_q[ptr_q] <= cmd;
        wr_addr_q     <= ptr_q;
      end
      if (tx_en) tx_byte_q <= regs_q[tx_addr];
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs[8*g +: 8] = regs_q[g];
  end

  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign tx_byte   = tx_byte_q;
  assign tx_load   = tx_load_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Bench for spi_reg_sequencer: frame vectors from a table plus hand-built corner
// sequences, with write/read pulses scored against a reference register model.
module tb_spi_reg_sequencer;

  localparam int NREGS = 16;
  localparam int AW    = 4;

  logic               clk;
  logic               rst;
  logic               SSEL;
  logic [7:0]         cmd;
  logic               cmd_valid;
  logic [NREGS*8-1:0] regs;
  logic               wr_strobe;
  logic [AW-1:0]      wr_addr;
  logic [7:0]         tx_byte;
  logic               tx_load;
  logic               addr_err;

  spi_reg_sequencer #(.NREGS(NREGS), .AW(AW), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .SSEL(SSEL), .cmd(cmd), .cmd_valid(cmd_valid),
    .regs(regs), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .tx_byte(tx_byte), .tx_load(tx_load), .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not complete");
  end

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         n;
    logic       exp_err;
    int         chk_addr;
    logic [7:0] chk_val;
  } vec_t;

  typedef struct {
    int         a;
    logic [7:0] d;
  } wr_t;

  vec_t       tbl [8];
  wr_t        wq [$];
  logic [7:0] rq [$];
  logic [7:0] m_regs [NREGS];
  int         m_idx, m_addr;
  logic       m_wr, m_drop;
  int         checks, failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance one clock and score any pulse the DUT produced on that edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (wr_strobe) begin
      if (wq.size() == 0) chk("wr_unexpected", 32'(wr_strobe), 32'd0);
      else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.a));
        chk("wr_data", 32'(regs[e.a*8 +: 8]), 32'(e.d));
      end
    end
    if (tx_load) begin
      if (rq.size() == 0) chk("tx_unexpected", 32'(tx_load), 32'd0);
      else chk("tx_byte", 32'(tx_byte), 32'(rq.pop_front()));
    end
  endtask

  task automatic model_byte(input logic [7:0] v);
    if (m_idx == 0) begin
      m_drop = (v[6:0] >= 7'(NREGS));
      m_wr   = v[7];
      m_addr = int'(v[6:0]) % NREGS;
      if (!m_drop && !m_wr) rq.push_back(m_regs[m_addr]);
    end else if (!m_drop) begin
      if (m_wr) begin
        wr_t e;
        e.a = m_addr;
        e.d = v;
        wq.push_back(e);
        m_regs[m_addr] = v;
        m_addr = (m_addr + 1) % NREGS;
      end else begin
        m_addr = (m_addr + 1) % NREGS;
        rq.push_back(m_regs[m_addr]);
      end
    end
    m_idx++;
  endtask

  task automatic send_byte(input logic [7:0] v, input bit modeled);
    cmd       = v;
    cmd_valid = 1'b1;
    if (modeled) model_byte(v);
    step();
    cmd_valid = 1'b0;
    step();
    step();
  endtask

  task automatic open_frame();
    SSEL  = 1'b0;
    m_idx = 0;
    repeat (4) step();
  endtask

  task automatic close_frame();
    SSEL = 1'b1;
    repeat (4) step();
    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("rq_drained", 32'(rq.size()), 32'd0);
  endtask

  task automatic check_bank(input string name);
    for (int i = 0; i < NREGS; i++) chk(name, 32'(regs[i*8 +: 8]), 32'(m_regs[i]));
  endtask

  task automatic set_vec(input int i, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input int n, input logic err,
                         input int ca, input logic [7:0] cv);
    tbl[i].b0 = b0; tbl[i].b1 = b1; tbl[i].b2 = b2; tbl[i].n = n;
    tbl[i].exp_err = err; tbl[i].chk_addr = ca; tbl[i].chk_val = cv;
  endtask

  initial begin
    checks = 0; failures = 0;
    m_idx = 0; m_addr = 0; m_wr = 1'b0; m_drop = 1'b0;
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;

    set_vec(0, 8'h83, 8'h11, 8'h22, 3, 1'b0,  4, 8'h22);
    set_vec(1, 8'h8F, 8'hAA, 8'hBB, 3, 1'b0,  0, 8'hBB);
    set_vec(2, 8'h03, 8'h00, 8'h00, 3, 1'b0,  3, 8'h11);
    set_vec(3, 8'hA0, 8'h55, 8'h00, 2, 1'b1,  0, 8'hBB);
    set_vec(4, 8'h81, 8'h01, 8'h00, 2, 1'b0,  1, 8'h01);
    set_vec(5, 8'h0F, 8'h00, 8'h00, 2, 1'b0, 15, 8'hAA);
    set_vec(6, 8'h10, 8'h00, 8'h00, 2, 1'b1,  0, 8'hBB);
    set_vec(7, 8'h85, 8'h7E, 8'hC3, 3, 1'b0,  6, 8'hC3);

    rst = 1'b1; SSEL = 1'b1; cmd = 8'h00; cmd_valid = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_regs", 32'(regs == '0), 32'd1);
    chk("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'd0);
    chk("rst_tx_load", 32'(tx_load), 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);

    for (int v = 0; v < 8; v++) begin
      open_frame();
      send_byte(tbl[v].b0, 1'b1);
      if (tbl[v].n > 1) send_byte(tbl[v].b1, 1'b1);
      if (tbl[v].n > 2) send_byte(tbl[v].b2, 1'b1);
      close_frame();
      chk($sformatf("vec%0d_addr_err", v), 32'(addr_err), 32'(tbl[v].exp_err));
      chk($sformatf("vec%0d_reg", v), 32'(regs[tbl[v].chk_addr*8 +: 8]), 32'(tbl[v].chk_val));
    end
    check_bank("table_bank");

    // Empty frame: nothing may change.
    open_frame();
    close_frame();
    chk("empty_addr_err", 32'(addr_err), 32'd0);
    check_bank("empty_bank");

    // Frame ends after one data byte; a later stray byte in IDLE is ignored.
    open_frame();
    send_byte(8'h82, 1'b1);
    send_byte(8'h99, 1'b1);
    close_frame();
    send_byte(8'h44, 1'b0);
    chk("idle_reg2", 32'(regs[2*8 +: 8]), 32'h99);
    chk("idle_reg3", 32'(regs[3*8 +: 8]), 32'h11);

    // Byte arriving in the same cycle the frame-end edge is seen.
    open_frame();
    send_byte(8'h87, 1'b1);
    SSEL = 1'b1;
    step(); step();
    cmd = 8'h5A; cmd_valid = 1'b1;
    model_byte(8'h5A);
    step();
    cmd_valid = 1'b0;
    repeat (3) step();
    send_byte(8'h66, 1'b0);
    chk("edge_reg7", 32'(regs[7*8 +: 8]), 32'h5A);
    chk("edge_reg8", 32'(regs[8*8 +: 8]), 32'h00);
    chk("edge_wq", 32'(wq.size()), 32'd0);

    // Short deassert mid-frame: the next byte is treated as a fresh header.
    open_frame();
    send_byte(8'h89, 1'b1);
    send_byte(8'h12, 1'b1);
    SSEL = 1'b1;
    step();
    open_frame();
    send_byte(8'h8A, 1'b1);
    send_byte(8'h34, 1'b1);
    close_frame();
    chk("glitch_reg9", 32'(regs[9*8 +: 8]), 32'h12);
    chk("glitch_reg10", 32'(regs[10*8 +: 8]), 32'h34);

    // Reset mid-frame: bank clears and the rest of the frame is ignored.
    open_frame();
    send_byte(8'h8B, 1'b1);
    send_byte(8'h01, 1'b1);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    step();
    chk("midrst_regs", 32'(regs == '0), 32'd1);
    chk("midrst_tx_byte", 32'(tx_byte), 32'd0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h78, 1'b0);
    close_frame();
    check_bank("midrst_bank");

    open_frame();
    send_byte(8'h82, 1'b1);
    send_byte(8'h05, 1'b1);
    close_frame();
    chk("recover_reg2", 32'(regs[2*8 +: 8]), 32'h05);
    check_bank("final_bank");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
